// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, the default
// byte address mapped to SRAM halfword 0, and the SRAM data bus width.
package sram_controller_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int unsigned SRAM_DATA_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/sram_controller_if.sv
// Bus bundle between the memory stage, the SRAM controller and the external
// asynchronous SRAM.
//   Pipeline side : mem_r_en, mem_w_en, address, write_data -> controller
//                   read_data, ready                        <- controller
//   SRAM side     : sram_addr, sram_we_n, sram_dq_out, sram_dq_oe <- controller
//                   sram_dq_in                                   -> controller
// master = pipeline/SRAM-model view, slave = controller view.
interface sram_controller_if #(
  parameter int unsigned SRAM_ADDR_W = 18
);
  logic                                        mem_r_en;
  logic                                        mem_w_en;
  logic [31:0]                                 address;
  logic [31:0]                                 write_data;
  logic [31:0]                                 read_data;
  logic                                        ready;
  logic [SRAM_ADDR_W-1:0]                      sram_addr;
  logic                                        sram_we_n;
  logic [sram_controller_pkg::SRAM_DATA_W-1:0] sram_dq_out;
  logic                                        sram_dq_oe;
  logic [sram_controller_pkg::SRAM_DATA_W-1:0] sram_dq_in;

  modport master (
    output mem_r_en, mem_w_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_controller.sv
// Multi-cycle controller between the memory stage and a 16-bit asynchronous
// SRAM. Each 32-bit access is split into a low and a high halfword access;
// ready stays low while the access is in flight so the pipeline freezes.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - sram_controller_if.slave (pipeline request/response + SRAM pins)
// All SRAM pins are registered; ready is combinational from state/request.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic            clk,
  input  logic            rst,
  sram_controller_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ACCESS_CYCLES - 4);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SRAM_ADDR_W-2:0]   word_q, word_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     is_wr_q, is_wr_d;
  logic [SRAM_DATA_W-1:0]   rd_lo_q, rd_lo_d;
  logic [31:0]              read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                     sram_we_n_q, sram_we_n_d;
  logic [SRAM_DATA_W-1:0]   sram_dq_out_q, sram_dq_out_d;
  logic                     sram_dq_oe_q, sram_dq_oe_d;

  // Only the low SRAM_ADDR_W+1 bits of (address - BASE_ADDR) matter; modular
  // subtraction on the truncated operands yields the same bits.
  logic [SRAM_ADDR_W:0]     off;
  logic                     req;
  logic                     unused_off_lsbs;

  assign unused_off_lsbs = ^off[1:0];

  always_comb begin
    off           = bus.address[SRAM_ADDR_W:0] - BASE_ADDR[SRAM_ADDR_W:0];
    req           = bus.mem_r_en | bus.mem_w_en;
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    is_wr_d       = is_wr_q;
    rd_lo_d       = rd_lo_q;
    read_data_d   = read_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_we_n_d   = 1'b1;
    sram_dq_oe_d  = 1'b0;
    // SRAM pins are registered, so each state sets up the pins for the next.
    unique case (state_q)
      IDLE: begin
        if (req) begin
          word_d        = off[SRAM_ADDR_W:2];
          wdata_d       = bus.write_data;
          is_wr_d       = bus.mem_w_en;
          sram_addr_d   = {off[SRAM_ADDR_W:2], 1'b0};
          sram_we_n_d   = ~bus.mem_w_en;
          sram_dq_oe_d  = bus.mem_w_en;
          sram_dq_out_d = bus.write_data[15:0];
          state_d       = LO;
        end
      end
      LO: begin
        if (!is_wr_q) rd_lo_d = bus.sram_dq_in;
        sram_addr_d   = {word_q, 1'b1};
        sram_we_n_d   = ~is_wr_q;
        sram_dq_oe_d  = is_wr_q;
        sram_dq_out_d = wdata_q[31:16];
        state_d       = HI;
      end
      HI: begin
        if (!is_wr_q) read_data_d = {bus.sram_dq_in, rd_lo_q};
        cnt_d   = WAIT_LOAD;
        state_d = (WAIT_LOAD == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      wdata_q       <= '0;
      is_wr_q       <= 1'b0;
      rd_lo_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      is_wr_q       <= is_wr_d;
      rd_lo_q       <= rd_lo_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
    end
  end

  // Freeze starts in the request cycle itself; DONE releases the pipeline.
  assign bus.ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_we_n   = sram_we_n_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;

endmodule
